decimal_key_encoder: RTL

- Converts ten active-high decimal key lines (key 0..9) into a 4-bit BCD digit with a one-cycle valid strobe.
- Synchronises the asynchronous key lines, debounces press and release, and rejects multi-key chords.
- Sits between a front-panel or keypad input and the BCD datapath that feeds the existing BCD-to-decimal display decoding.

---
 rtl/decimal_pkg.sv | 16 +
 rtl/onehot10_to_bcd.sv | 25 ++
 rtl/decimal_key_encoder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/decimal_pkg.sv
// Shared types and constants for the decimal key encoder.
package decimal_pkg;

    localparam int NUM_KEYS = 10;

    typedef logic [3:0]          bcd_t;
    typedef logic [NUM_KEYS-1:0] dec_onehot_t;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } key_state_t;

endpackage

// File: rtl/onehot10_to_bcd.sv
// Combinational ten-line to BCD encoder. The index is the OR of all set-bit
// indices (no priority); one_hot_ok_o qualifies it as meaningful.
module onehot10_to_bcd
    import decimal_pkg::*;
(
    input  dec_onehot_t onehot_i,
    output bcd_t        bcd_o,
    output logic        one_hot_ok_o
);

    logic [3:0] ones;

    always_comb begin
        bcd_o = '0;
        ones  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (onehot_i[i]) begin
                bcd_o = bcd_o | bcd_t'(i);
                ones  = ones + 4'd1;
            end
        end
        one_hot_ok_o = (ones == 4'd1);
    end

endmodule

// File: rtl/decimal_key_encoder.sv
// Synchronises, debounces and encodes ten decimal key lines into a BCD digit.
// Optional digit history register enabled by defining KEY_HISTORY_EN.
module decimal_key_encoder
    import decimal_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
`ifdef KEY_HISTORY_EN
    , parameter int HIST_DEPTH = 4
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  dec_onehot_t key_in,
    output bcd_t        bcd,
    output logic        bcd_valid,
    output logic        multi_err,
    output logic        key_held
`ifdef KEY_HISTORY_EN
    , output logic [4*HIST_DEPTH-1:0] digits
`endif
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dec_onehot_t      sync1_q, samp_q;
    dec_onehot_t      cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_state_t       state_q, state_d;
    bcd_t             bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    bcd_t enc_bcd;
    logic enc_ok;

    onehot10_to_bcd u_enc (
        .onehot_i     (cand_q),
        .bcd_o        (enc_bcd),
        .one_hot_ok_o (enc_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            samp_q  <= '0;
        end else begin
            sync1_q <= key_in;
            samp_q  <= sync1_q;
        end
    end

    // Evaluation happens on the edge after the counter has reached the limit,
    // so the candidate has been seen on DEBOUNCE_CYCLES+1 consecutive samples.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (samp_q != '0) begin
                    cand_d  = samp_q;
                    cnt_d   = CNT_ONE;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (samp_q == '0) begin
                    state_d = IDLE;
                end else if (samp_q != cand_q) begin
                    cand_d = samp_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    if (enc_ok) begin
                        bcd_d   = enc_bcd;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (samp_q == '0) begin
                    cnt_d   = CNT_ONE;
                    state_d = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (samp_q != '0) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign multi_err = err_q;
    assign key_held  = (state_q == HELD) || (state_q == DEB_RELEASE);

`ifdef KEY_HISTORY_EN
    logic [4*HIST_DEPTH-1:0] dig_q, dig_d;

    // Newest digit enters the low nibble; shift-then-patch avoids a
    // zero-width slice when HIST_DEPTH is 1.
    always_comb begin
        dig_d = dig_q;
        if (valid_d) begin
            dig_d      = dig_q << 4;
            dig_d[3:0] = enc_bcd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dig_q <= '0;
        else        dig_q <= dig_d;
    end

    assign digits = dig_q;
`endif

endmodule
